// File: rtl/rng_word_fetch_pkg.sv
// rng_word_fetch_pkg
// Shared definitions for the RNG word fetcher: the FSM state encoding and
// the default word width and FIFO depth.
package rng_word_fetch_pkg;

    localparam int RNG_NUM_BITS   = 32;
    localparam int RNG_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/rng_word_fetch_fifo.sv
// rng_fifo
// Synchronous FIFO for words returned by the RNG.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   push         write push_data at this edge (ignored when full)
//   push_data    word to store
//   pop          drop the head word at this edge (ignored when empty)
//   flush        empty the FIFO; takes priority over push and pop
//   count        number of stored words, 0..DEPTH
//   head_data    oldest stored word
module rng_fifo
    import rng_word_fetch_pkg::*;
#(
    parameter int NUM_BITS = RNG_NUM_BITS,
    parameter int DEPTH    = RNG_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [NUM_BITS-1:0]      push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [NUM_BITS-1:0]      head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [NUM_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign do_push   = push && (count != FULL_CNT);
    assign do_pop    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    // Storage is cleared on reset so head_data reads 0 out of reset.
    // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rng_word_fetch.sv
// rng_word_fetch
// Initiator for the RNG dat_* register interface. Reads words from the RNG
// into a small FIFO for downstream samplers, and writes a new seed on request,
// which flushes any buffered words.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   run                     fetch words while high
//   rng_enable              registered copy of run, to the RNG enable
//   dat_re/dat_we           read / write strobes, held until !dat_wait
//   dat_di                  seed write data (holds last seed)
//   dat_do                  read data, sampled at the completion edge
//   dat_wait                RNG stall
//   seed_valid/seed_ready   seed handshake, seed_data is the seed word
//   out_valid/out_ready     consumer handshake, out_data is the FIFO head
//
// state  | meaning
// IDLE   | no transfer in flight; accepts a seed or starts a read
// READ   | dat_re high; completion pushes dat_do into the FIFO
// WRITE  | dat_we high with the seed on dat_di; completion flushes the FIFO
module rng_word_fetch
    import rng_word_fetch_pkg::*;
#(
    parameter int NUM_BITS   = RNG_NUM_BITS,
    parameter int FIFO_DEPTH = RNG_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                rng_enable,
    output logic                dat_re,
    output logic                dat_we,
    output logic [NUM_BITS-1:0] dat_di,
    input  logic [NUM_BITS-1:0] dat_do,
    input  logic                dat_wait,
    input  logic                seed_valid,
    output logic                seed_ready,
    input  logic [NUM_BITS-1:0] seed_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] out_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic             xfer_done;
    logic             load_seed;
    logic             fifo_push;
    logic             fifo_flush;
    logic [CNT_W-1:0] fifo_count;

    assign xfer_done  = (dat_re || dat_we) && !dat_wait;
    assign seed_ready = (state == ST_IDLE);
    assign out_valid  = (fifo_count != '0);

    always_comb begin
        state_nxt  = state;
        load_seed  = 1'b0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        case (state)
            ST_IDLE: begin
                if (seed_valid) begin
                    load_seed = 1'b1;
                    state_nxt = ST_WRITE;
                end else if (run && (fifo_count != FULL_CNT)) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (xfer_done) begin
                    fifo_push = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (xfer_done) begin
                    fifo_flush = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they rise on the same
    // edge the FSM enters READ/WRITE and stay steady until completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            dat_re     <= 1'b0;
            dat_we     <= 1'b0;
            dat_di     <= '0;
            rng_enable <= 1'b0;
        end else begin
            state      <= state_nxt;
            dat_re     <= (state_nxt == ST_READ);
            dat_we     <= (state_nxt == ST_WRITE);
            rng_enable <= run;
            if (load_seed) begin
                dat_di <= seed_data;
            end
        end
    end

    rng_fifo #(
        .NUM_BITS (NUM_BITS),
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (dat_do),
        .pop       (out_ready),
        .flush     (fifo_flush),
        .count     (fifo_count),
        .head_data (out_data)
    );

endmodule

// File: tb/tb_rng_word_fetch.sv
// tb_rng_word_fetch
// Directed bench for rng_word_fetch with a small RNG responder that returns
// 1, 2, 3, ... per completed read and stalls for wait_cfg cycles per transfer.
module tb_rng_word_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        rng_enable;
    logic        dat_re;
    logic        dat_we;
    logic [31:0] dat_di;
    logic [31:0] dat_do;
    logic        dat_wait;
    logic        seed_valid;
    logic        seed_ready;
    logic [31:0] seed_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    int          wait_cfg = 0;
    int          wait_ctr;
    logic [31:0] rng_word;

    int re_cnt;
    int we_cnt;
    int re_run;
    int re_run_max;
    int both_cnt;

    always #5 clk = ~clk;

    rng_word_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .rng_enable (rng_enable),
        .dat_re     (dat_re),
        .dat_we     (dat_we),
        .dat_di     (dat_di),
        .dat_do     (dat_do),
        .dat_wait   (dat_wait),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed_data  (seed_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    // RNG responder
    assign dat_wait = (dat_re || dat_we) && (wait_ctr < wait_cfg);
    assign dat_do   = rng_word;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rng_word <= 32'd1;
            wait_ctr <= 0;
        end else if (dat_re || dat_we) begin
            if (!dat_wait) begin
                wait_ctr <= 0;
                if (dat_re) rng_word <= rng_word + 32'd1;
            end else begin
                wait_ctr <= wait_ctr + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Run for n cycles, sampling strobes at each falling edge; run drops
    // after run_hi samples.
    task automatic observe(input int n, input int run_hi);
        re_cnt = 0; we_cnt = 0; re_run = 0; re_run_max = 0; both_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dat_re) begin
                re_cnt++;
                re_run++;
                if (re_run > re_run_max) re_run_max = re_run;
            end else begin
                re_run = 0;
            end
            if (dat_we) we_cnt++;
            if (dat_re && dat_we) both_cnt++;
            if (i + 1 == run_hi) run = 1'b0;
        end
    endtask

    task automatic do_reset();
        run = 1'b0; seed_valid = 1'b0; out_ready = 1'b0; wait_cfg = 0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; seed_valid = 1'b0; seed_data = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_dat_re", {31'd0, dat_re}, 32'd0);
        check("rst_dat_we", {31'd0, dat_we}, 32'd0);
        check("rst_dat_di", dat_di, 32'd0);
        check("rst_rng_enable", {31'd0, rng_enable}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_seed_ready", {31'd0, seed_ready}, 32'd1);

        // Fill to full, zero wait
        run = 1'b1;
        check("rng_en_latency", {31'd0, rng_enable}, 32'd0);
        observe(20, 20);
        check("fill_re_count", re_cnt, 32'd4);
        check("fill_re_alternate", re_run_max, 32'd1);
        check("fill_re_stopped", {31'd0, dat_re}, 32'd0);
        check("fill_rng_enable", {31'd0, rng_enable}, 32'd1);
        check("fill_out_valid", {31'd0, out_valid}, 32'd1);
        check("fill_out_data", out_data, 32'd1);
        run = 1'b0;
        @(negedge clk);
        check("rng_en_drop", {31'd0, rng_enable}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("fill_drain_valid", {31'd0, out_valid}, 32'd1);
            check("fill_drain_data", out_data, 32'(k + 1));
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("fill_drain_empty", {31'd0, out_valid}, 32'd0);

        // Wait states: three stall cycles stretch one read to four cycles
        do_reset();
        wait_cfg = 3;
        run = 1'b1;
        observe(10, 1);
        check("wait_re_count", re_cnt, 32'd4);
        check("wait_re_consecutive", re_run_max, 32'd4);
        check("wait_out_data", out_data, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("wait_single_word", {31'd0, out_valid}, 32'd0);

        // Reseed with two words buffered
        do_reset();
        run = 1'b1;
        observe(8, 3);
        check("seed_prefill_re", re_cnt, 32'd2);
        check("seed_prefill_data", out_data, 32'd1);
        seed_valid = 1'b1; seed_data = 32'hDEADBEEF; run = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0; seed_data = 32'h0;
        check("seed_we_high", {31'd0, dat_we}, 32'd1);
        check("seed_no_re", {31'd0, dat_re}, 32'd0);
        check("seed_dat_di", dat_di, 32'hDEADBEEF);
        check("seed_ready_busy", {31'd0, seed_ready}, 32'd0);
        check("seed_valid_before", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        check("seed_we_one_cycle", {31'd0, dat_we}, 32'd0);
        check("seed_flushed", {31'd0, out_valid}, 32'd0);
        check("seed_di_holds", dat_di, 32'hDEADBEEF);
        @(negedge clk);
        check("seed_read_resumes", {31'd0, dat_re}, 32'd1);
        @(negedge clk);
        run = 1'b0;
        check("seed_new_word_valid", {31'd0, out_valid}, 32'd1);
        check("seed_new_word", out_data, 32'd3);

        // Simultaneous push and pop at count = 3
        do_reset();
        run = 1'b1;
        observe(8, 5);
        check("pp_prefill_re", re_cnt, 32'd3);
        run = 1'b1;
        @(negedge clk);
        check("pp_read_inflight", {31'd0, dat_re}, 32'd1);
        run = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("pp_head_advanced", out_data, 32'd2);
        for (int k = 0; k < 3; k++) begin
            check("pp_drain_valid", {31'd0, out_valid}, 32'd1);
            check("pp_drain_data", out_data, 32'(k + 2));
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("pp_count_was_3", {31'd0, out_valid}, 32'd0);

        // Reset during a stalled read
        do_reset();
        run = 1'b1;
        observe(4, 1);
        check("rs_word_buffered", {31'd0, out_valid}, 32'd1);
        wait_cfg = 10;
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rs_stalled_re", {31'd0, dat_re}, 32'd1);
        reset = 1'b1;
        #1;
        check("rs_async_re", {31'd0, dat_re}, 32'd0);
        check("rs_async_valid", {31'd0, out_valid}, 32'd0);
        check("rs_async_rng_en", {31'd0, rng_enable}, 32'd0);
        check("rs_async_data", out_data, 32'd0);
        @(negedge clk);
        reset = 1'b0; wait_cfg = 0;
        @(negedge clk);
        check("rs_restart_re", {31'd0, dat_re}, 32'd1);
        run = 1'b0;
        @(negedge clk);
        check("rs_restart_valid", {31'd0, out_valid}, 32'd1);
        check("rs_restart_data", out_data, 32'd1);
        check("rs_no_both", both_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
